// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - state encoding and step-count helper shared by the sequential multiplier
package mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_steps(input int len, input int step);
    return len / step;
  endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one radix-2^STEP partial-product accumulate, purely combinational
module mul_step #(
  parameter int LEN   = 16,
  parameter int STEP  = 1,
  parameter int POS_W = $clog2(2*LEN)
) (
  input  logic [2*LEN-1:0] acc_i,
  input  logic [LEN-1:0]   mcand_i,
  input  logic [STEP-1:0]  mbits_i,
  input  logic [POS_W-1:0] pos_i,
  output logic [2*LEN-1:0] acc_o
);

  logic [2*LEN-1:0] pp;

  always_comb begin
    pp    = {{LEN{1'b0}}, mcand_i} * {{(2*LEN-STEP){1'b0}}, mbits_i};
    acc_o = acc_i + (pp << pos_i);
  end

endmodule

// File: rtl/mul_seq_radix.sv
// rtl/mul_seq_radix.sv - sequential shift-add multiplier retiring STEP multiplier bits per cycle
module mul_seq_radix
  import mul_seq_pkg::*;
#(
  parameter int LEN  = 16,
  parameter int STEP = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SGN,
  input  logic [LEN-1:0]   A,
  input  logic [LEN-1:0]   B,
  output logic             BUSY,
  output logic             DONE,
  output logic [2*LEN-1:0] P,
  output logic [LEN-1:0]   Y
);

  localparam int N     = calc_steps(LEN, STEP);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int POS_W = $clog2(2*LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (STEP < 1 || STEP > LEN || (LEN % STEP) != 0) begin : g_bad_step
    $error("mul_seq_radix: STEP must divide LEN and lie in 1..LEN");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   a_q, a_d;
  logic [LEN-1:0]   b_q, b_d;
  logic             neg_q, neg_d;
  logic [2*LEN-1:0] acc_q, acc_d;
  logic [2*LEN-1:0] p_q, p_d;
  logic [2*LEN-1:0] acc_next;
  logic [POS_W-1:0] pos;

  always_comb begin
    pos = POS_W'(int'(cnt_q) * STEP);
  end

  mul_step #(
    .LEN  (LEN),
    .STEP (STEP),
    .POS_W(POS_W)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(a_q),
    .mbits_i(b_q[STEP-1:0]),
    .pos_i  (pos),
    .acc_o  (acc_next)
  );

  // Operands are held as magnitudes; the sign is reapplied once on the completion edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          a_d     = (SGN && A[LEN-1]) ? (~A + 1'b1) : A;
          b_d     = (SGN && B[LEN-1]) ? (~B + 1'b1) : B;
          neg_d   = SGN & (A[LEN-1] ^ B[LEN-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_next;
        b_d   = b_q >> STEP;
        if (cnt_q == CNT_LAST) begin
          p_d     = neg_q ? (~acc_next + 1'b1) : acc_next;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_DONE);
  assign P    = p_q;
  assign Y    = p_q[LEN-1:0];

endmodule

// File: tb/tb_mul_seq_radix.sv
// tb/tb_mul_seq_radix.sv - scoreboard bench for mul_seq_radix with STEP=1 and STEP=4 instances
module tb_mul_seq_radix;

  typedef struct {
    logic [31:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic        sgn   [2];
  logic [15:0] a     [2];
  logic [15:0] b     [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] p     [2];
  logic [15:0] y     [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] hold      [2];
  logic        done_prev [2];
  logic        rst_prev;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_radix #(.LEN(16), .STEP(1)) u_s1 (
    .CLK(clk), .RST(rst), .START(start[0]), .SGN(sgn[0]), .A(a[0]), .B(b[0]),
    .BUSY(busy[0]), .DONE(done[0]), .P(p[0]), .Y(y[0])
  );

  mul_seq_radix #(.LEN(16), .STEP(4)) u_s4 (
    .CLK(clk), .RST(rst), .START(start[1]), .SGN(sgn[1]), .A(a[1]), .B(b[1]),
    .BUSY(busy[1]), .DONE(done[1]), .P(p[1]), .Y(y[1])
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv, input logic s);
    longint x;
    longint z;
    longint pr;
    x  = s ? longint'($signed(av)) : longint'(av);
    z  = s ? longint'($signed(bv)) : longint'(bv);
    pr = x * z;
    return pr[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (rst_prev) hold[u] = 32'h0;
      if (busy[u]) chk(u == 0 ? "p_hold_s1" : "p_hold_s4", p[u], hold[u]);
      if (done[u] && !done_prev[u]) begin
        if ((u == 0 ? q0.size() : q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: instance %0d got DONE with no request pending", u);
        end else begin
          e = (u == 0) ? q0.pop_front() : q1.pop_front();
          chk(u == 0 ? "product_s1" : "product_s4", p[u], e.p);
          chk("y_low_half", {16'h0, y[u]}, {16'h0, e.p[15:0]});
          chk(u == 0 ? "latency_s1" : "latency_s4", 32'(cyc), 32'(e.cyc));
          chk("busy_in_done", {31'h0, busy[u]}, 32'h0);
          hold[u] = e.p;
        end
      end
      done_prev[u] = done[u];
    end
    rst_prev = rst;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int u, input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input bit expect_done);
    exp_t e;
    e.p   = ref_mul(av, bv, s);
    e.cyc = cyc + 1 + ((u == 0) ? 16 : 4);
    start[u] = 1'b1;
    sgn[u]   = s;
    a[u]     = av;
    b[u]     = bv;
    if (expect_done) begin
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    tick;
    start[u] = 1'b0;
    a[u]     = 16'($urandom);
    b[u]     = 16'($urandom);
    sgn[u]   = 1'($urandom);
  endtask

  task automatic wait_done(input int u);
    int n = 0;
    while (!done[u] && n < 64) begin
      tick;
      n++;
    end
    if (!done[u]) begin
      checks++;
      errors++;
      $display("FAIL wait_done: instance %0d DONE never rose within 64 cycles", u);
    end
  endtask

  initial begin
    logic [15:0] sa [3];
    logic [15:0] sb [3];
    logic [31:0] sp [3];
    sa = '{16'hFFFE, 16'h8000, 16'hFFFF};
    sb = '{16'h0003, 16'h8000, 16'hFFFF};
    sp = '{32'hFFFFFFFA, 32'h40000000, 32'h00000001};
    rst_prev = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; sgn[u] = 1'b0; a[u] = 16'h0; b[u] = 16'h0;
      hold[u] = 32'h0; done_prev[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      chk("reset_done", {31'h0, done[u]}, 32'h0);
      chk("reset_busy", {31'h0, busy[u]}, 32'h0);
      chk("reset_p", p[u], 32'h0);
    end

    issue(0, 1'b0, 16'hFFFF, 16'hFFFF, 1);
    chk("busy_after_start", {31'h0, busy[0]}, 32'h1);
    wait_done(0);
    chk("ffff_sq_p", p[0], 32'hFFFE0001);
    chk("ffff_sq_y", {16'h0, y[0]}, 32'h00000001);

    for (int i = 0; i < 3; i++) begin
      issue(0, 1'b1, sa[i], sb[i], 1);
      wait_done(0);
      chk("signed_corner", p[0], sp[i]);
    end

    issue(0, 1'b0, 16'd5, 16'd7, 1);
    repeat (4) tick;
    start[0] = 1'b1; a[0] = 16'd9; b[0] = 16'd9; sgn[0] = 1'b0;
    tick;
    start[0] = 1'b0;
    wait_done(0);
    chk("start_in_run_ignored", p[0], 32'h00000023);
    tick;
    chk("busy_low_after_done", {31'h0, busy[0]}, 32'h0);
    chk("done_held", {31'h0, done[0]}, 32'h1);

    issue(0, 1'b0, 16'h1234, 16'h0077, 0);
    repeat (7) tick;
    rst = 1'b1; start[0] = 1'b1; a[0] = 16'h0003; b[0] = 16'h0004;
    tick;
    rst = 1'b0; start[0] = 1'b0;
    chk("abort_done", {31'h0, done[0]}, 32'h0);
    chk("abort_busy", {31'h0, busy[0]}, 32'h0);
    chk("abort_p", p[0], 32'h0);
    tick;
    chk("abort_start_lost", {31'h0, busy[0]}, 32'h0);
    issue(0, 1'b0, 16'h0101, 16'h0202, 1);
    wait_done(0);

    for (int i = 0; i < 100; i++) begin
      if (i != 0) wait_done(1);
      issue(1, 1'(i % 2), 16'(i * 193), 16'(i * 1543), 1);
    end
    for (int i = 0; i < 30; i++) begin
      wait_done(1);
      issue(1, 1'($urandom), 16'($urandom), 16'($urandom), 1);
    end
    for (int i = 0; i < 12; i++) begin
      wait_done(0);
      issue(0, 1'($urandom), 16'($urandom), 16'($urandom), 1);
    end
    wait_done(0);
    wait_done(1);
    repeat (2) tick;
    chk("queue_s1_drained", 32'(q0.size()), 32'h0);
    chk("queue_s4_drained", 32'(q1.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
